// File: rtl/isdu_ctrl.sv
// rtl/isdu_ctrl.sv - Moore instruction-sequencing FSM (fetch/decode/branch/jump).
// Optional PAUSE instruction (opcode 1101) enabled by defining ISDU_PAUSE_EN.
module isdu_ctrl (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       BEN,
    output logic       LD_IR,
    output logic       LD_MDR,
    output logic       LD_MAR,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic [3:0] State_Dbg
);

    typedef enum logic [3:0] {
        HALTED  = 4'd0,
        S_18    = 4'd1,
        S_33_1  = 4'd2,
        S_33_2  = 4'd3,
        S_33_3  = 4'd4,
        S_35    = 4'd5,
        S_32    = 4'd6,
        S_00    = 4'd7,
        S_22    = 4'd8,
`ifdef ISDU_PAUSE_EN
        S_12    = 4'd9,
        PAUSE_1 = 4'd10,
        PAUSE_2 = 4'd11
`else
        S_12    = 4'd9
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

`ifndef ISDU_PAUSE_EN
    logic unused_continue;
    assign unused_continue = Continue;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = HALTED;
        unique case (state_q)
            HALTED:  state_d = Run ? S_18 : HALTED;
            S_18:    state_d = S_33_1;
            S_33_1:  state_d = S_33_2;
            S_33_2:  state_d = S_33_3;
            S_33_3:  state_d = S_35;
            S_35:    state_d = S_32;
            S_32: begin
                case (Opcode)
                    4'b0000: state_d = S_00;
                    4'b1100: state_d = S_12;
`ifdef ISDU_PAUSE_EN
                    4'b1101: state_d = PAUSE_1;
`endif
                    default: state_d = S_18;
                endcase
            end
            S_00:    state_d = BEN ? S_22 : S_18;
            S_22:    state_d = S_18;
            S_12:    state_d = S_18;
`ifdef ISDU_PAUSE_EN
            PAUSE_1: state_d = Continue ? PAUSE_2 : PAUSE_1;
            PAUSE_2: state_d = Continue ? PAUSE_2 : S_18;
`endif
            // Any encoding outside the enumerated set recovers to HALTED.
            default: state_d = HALTED;
        endcase
    end

    always_comb begin
        LD_IR      = 1'b0;
        LD_MDR     = 1'b0;
        LD_MAR     = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        case (state_q)
            S_18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                PCMUX  = 2'b00;
            end
            S_33_1, S_33_2: Mem_OE = 1'b0;
            S_33_3: begin
                Mem_OE = 1'b0;
                LD_MDR = 1'b1;
            end
            S_35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_22: begin
                LD_PC = 1'b1;
                PCMUX = 2'b10;
            end
            S_12: begin
                GateALU = 1'b1;
                LD_PC   = 1'b1;
                PCMUX   = 2'b01;
            end
            default: ;
        endcase
    end

    assign State_Dbg = state_q;

endmodule
